phase_seq_gen: RTL and testbench
================================

Name: phase_seq_gen

Overview:
- Parametrised successor to the processor's fixed 4-phase one-hot sequencer (fetch/decode/execute/interrupt).
- Generates a one-hot phase vector of NPHASE phases, with:
  - a programmable dwell time per phase,
  - a global stall,
  - an early return to phase 0 (skip),
  - halt/resume at instruction boundaries.
- Sits between the control decoder and the datapath; phase bits gate register-load enables.

Parameters:
- NPHASE, 4, number of phases (>=2); bit NPHASE-1 is phase 0 (fetch), bit 0 is the last phase.
- CNT_W, 4, width of each per-phase dwell count.
- IDX_W, 2, width of phase_idx; must satisfy 2**IDX_W >= NPHASE.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  reset; synchronous, active-high.
- en  input  1  advance enable; 0 freezes all state (stall).
- skip  input  1  abort the remainder of the current instruction; go to phase 0.
- halt_req  input  1  request halt at the next instruction boundary.
- go  input  1  leave IDLE or HALTED.
- dwell_cfg  input  NPHASE*CNT_W  extra cycles per phase.
  - Slice [(k+1)*CNT_W-1 : k*CNT_W] belongs to phase index k.
  - Phase index 0 = fetch.
- phase  output  NPHASE  one-hot phase, registered; MSB = fetch; all-zero when not running.
- phase_idx  output  IDX_W  binary index of the active phase; 0 when not running.
- phase_first  output  1  high on the first cycle of each phase occupancy.
- instr_done  output  1  one-cycle pulse on the cycle the last phase completes.
- halted  output  1  high while in HALTED.

Behaviour:
- Control FSM states: IDLE, RUN, HALTED.
- Reset (clr=1 at a clock edge, overrides every input), all registered:
  - state=IDLE, phase=0, phase_idx=0, dwell counter=0;
  - phase_first=0, instr_done=0, halted=0.
- IDLE:
  - go=1 and en=1 -> RUN, phase index 0, phase_first=1 next cycle.
  - Otherwise hold.
- RUN, with en=1:
  - Dwell counter counts 0..dwell_cfg[current].
  - While counter < cfg: counter+1, same phase.
  - At counter == cfg: advance to index (p+1) mod NPHASE, counter=0, phase_first=1.
  - Phase with cfg=0 lasts exactly one cycle; cfg=N lasts N+1 cycles.
  - The reset-default all-zero config reproduces the legacy 4-phase rotation, one cycle per phase.
  - dwell_cfg is sampled every cycle; changing it mid-phase takes effect on the next comparison.
- Leaving the last phase (index NPHASE-1): instr_done=1 for that cycle (combinational, coincident with the final cycle).
  - halt_req=1 in that cycle -> HALTED (phase=0, halted=1).
  - Otherwise wrap to phase 0.
- halt_req outside the last-phase completion cycle is ignored; it is not latched and must be held by the requester.
- skip=1 in RUN with en=1:
  - Next cycle: phase 0, counter=0, phase_first=1.
  - instr_done is not asserted.
  - halt_req is not evaluated.
- skip=1 during phase 0 restarts phase 0 with counter cleared.
- Priority: clr > en=0 > skip > halt at boundary > normal advance.
- en=0: phase, counter and state frozen; phase_first and instr_done forced 0.
- HALTED:
  - go=1 and en=1 -> RUN at phase 0.
  - skip and halt_req are ignored.
- go is ignored in RUN.
- Illegal/non-one-hot phase register (e.g. after an SEU) in RUN -> IDLE next cycle, mirroring the legacy default arm.
- Invariants:
  - Exactly one phase bit is set in RUN.
  - phase_idx is consistent with phase.
  - phase is all zero in IDLE and HALTED.
- Latency: output phase changes exactly one clock after the qualifying edge condition; no combinational path from inputs to phase.

Decomposition:
- Shared package seq_pkg holds:
  - FSM state encodings ST_IDLE, ST_RUN, ST_HALT;
  - localparam PH_FETCH=0;
  - a function onehot_to_idx used by the decoder as well.
- One natural sub-module: dwell_ctr (CNT_W-bit loadable up-counter with compare-equal output and synchronous clear), instantiated once.
- Next-phase rotate logic stays in the top module.

Test Plan:
- Reset default rotation: clr=1 for 2 cycles, then go=1, en=1, dwell_cfg=0, NPHASE=4.
  - phase = 0000, 1000, 0100, 0010, 0001, 1000 on consecutive cycles.
  - instr_done pulses once per 4 cycles, in the 0001 cycle.
- Dwell: dwell_cfg = {0,2,1,0}, phase indices 3..0.
  - Phase 0 lasts 1 cycle, phase 1 lasts 2, phase 2 lasts 3, phase 3 lasts 1.
  - Instruction = 7 cycles; phase_first high exactly 4 times per instruction.
- Stall: en=0 for 3 cycles mid-phase 2 with cfg=1 at counter=1.
  - phase holds 0010 and phase_first/instr_done stay 0.
  - On en=1 the phase advances after exactly one more cycle.
- Skip, and skip vs halt: skip=1 in phase 1 (0100).
  - Next cycle phase=1000, no instr_done.
  - skip=1 with halt_req=1 in the last phase -> phase 0, halted stays 0.
- Halt/resume: halt_req=1 through the last phase.
  - Next cycle phase=0000, halted=1, held for 5 cycles.
  - go=1 -> phase=1000, halted=0.
- Mid-operation reset and NPHASE=6 build: clr=1 while in phase 3 -> next cycle all outputs 0 and state IDLE.
  - For NPHASE=6, IDX_W=3: phase_idx sequences 0..5 and wraps to 0.
  - A force-injected phase of 101000 returns to IDLE.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pkg (package)
//  Purpose  : Shared definitions for the phase sequencer: control FSM state
//             encodings, the fetch phase index and a one-hot to binary
//             index helper used by the phase decoder.
//  Revision : 1.0  initial release
// ============================================================================
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Phase index of the fetch phase (carried on the MSB of the phase vector).
    localparam int PH_FETCH = 0;

    // Converts a one-hot phase vector of width n (MSB = index 0) to its
    // binary phase index. An all-zero vector yields 0.
    function automatic logic [31:0] onehot_to_idx(input logic [31:0] vec, input int n);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if ((i < n) && vec[i]) begin
                result = 32'(n - 1 - i);
            end
        end
        return result;
    endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/dwell_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : dwell_ctr
//  Purpose  : Loadable up-counter measuring the time spent in one phase,
//             with an equality compare against the programmed dwell value.
//  Ports    : clk      - clock
//             clr      - synchronous clear (highest priority)
//             load     - load load_val into the counter
//             load_val - value to load
//             inc      - increment by one
//             cmp_val  - compare value
//             count    - current count
//             eq       - count == cmp_val (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module dwell_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] cmp_val,
    output logic [W-1:0] count,
    output logic         eq
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign eq    = (r_count == cmp_val);

endmodule : dwell_ctr
`default_nettype wire

// File: rtl/phase_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : phase_seq_gen
//  Purpose  : Parametrised one-hot phase sequencer with per-phase dwell,
//             global stall, skip-to-fetch and halt/resume at instruction
//             boundaries.
//  Ports    : clk         - clock
//             clr         - synchronous active-high reset
//             en          - advance enable (0 = stall)
//             skip        - abort instruction, return to fetch
//             halt_req    - halt at the next instruction boundary
//             go          - leave IDLE / HALTED
//             dwell_cfg   - extra cycles per phase, CNT_W bits per phase index
//             phase       - registered one-hot phase, MSB = fetch
//             phase_idx   - binary index of the active phase
//             phase_first - first cycle of a phase occupancy
//             instr_done  - pulse on the final cycle of the last phase
//             halted      - high while halted
//  Revision : 1.0  initial release
// ============================================================================
module phase_seq_gen
    import seq_pkg::*;
#(
    parameter int NPHASE = 4,
    parameter int CNT_W  = 4,
    parameter int IDX_W  = 2
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    skip,
    input  logic                    halt_req,
    input  logic                    go,
    input  logic [NPHASE*CNT_W-1:0] dwell_cfg,
    output logic [NPHASE-1:0]       phase,
    output logic [IDX_W-1:0]        phase_idx,
    output logic                    phase_first,
    output logic                    instr_done,
    output logic                    halted
);

    localparam logic [NPHASE-1:0] C_FETCH = NPHASE'(1) << (NPHASE - 1 - PH_FETCH);

    state_t            r_state;
    logic [NPHASE-1:0] r_phase;
    logic              r_first;
    logic              r_halted;

    logic [IDX_W-1:0]  w_idx;
    logic [CNT_W-1:0]  w_cfg;
    logic [CNT_W-1:0]  w_count;
    logic              w_eq;
    logic              w_legal;
    logic              w_run;
    logic              w_active;
    logic              w_done;
    logic              w_ctr_clr;
    logic              w_ctr_inc;

    // Dwell table padded to the full index range so that any decoded index
    // selects a defined entry.
    logic [CNT_W-1:0]  w_cfg_tab [2**IDX_W];

    for (genvar k = 0; k < 2**IDX_W; k++) begin : g_cfg
        if (k < NPHASE) begin : g_used
            assign w_cfg_tab[k] = dwell_cfg[k*CNT_W +: CNT_W];
        end else begin : g_pad
            assign w_cfg_tab[k] = '0;
        end
    end

    assign w_idx   = IDX_W'(onehot_to_idx(32'(r_phase), NPHASE));
    assign w_cfg   = w_cfg_tab[w_idx];
    assign w_legal = (r_phase != '0) && ((r_phase & (r_phase - 1'b1)) == '0);
    assign w_run   = (r_state == ST_RUN);
    assign w_active = en && w_run && w_legal;

    // Last phase completes this cycle: the instruction boundary.
    assign w_done  = !clr && w_active && !skip && w_eq && r_phase[0];

    // Counter restarts on every phase change, skip, illegal phase or
    // whenever the sequencer is not running; it holds during a stall.
    assign w_ctr_clr = clr || (en && (!w_run || !w_legal || skip || w_eq));
    assign w_ctr_inc = w_active && !skip && !w_eq;

    dwell_ctr #(
        .W (CNT_W)
    ) u_dwell_ctr (
        .clk      (clk),
        .clr      (w_ctr_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (w_ctr_inc),
        .cmp_val  (w_cfg),
        .count    (w_count),
        .eq       (w_eq)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= ST_IDLE;
            r_phase  <= '0;
            r_first  <= 1'b0;
            r_halted <= 1'b0;
        end else if (!en) begin
            r_first  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (go) begin
                        r_state  <= ST_RUN;
                        r_phase  <= C_FETCH;
                        r_first  <= 1'b1;
                        r_halted <= 1'b0;
                    end else begin
                        r_phase  <= '0;
                        r_first  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!w_legal) begin
                        // Corrupted phase register: fall back to IDLE.
                        r_state <= ST_IDLE;
                        r_phase <= '0;
                        r_first <= 1'b0;
                    end else if (skip) begin
                        r_phase <= C_FETCH;
                        r_first <= 1'b1;
                    end else if (w_eq) begin
                        if (r_phase[0]) begin
                            if (halt_req) begin
                                r_state  <= ST_HALT;
                                r_phase  <= '0;
                                r_first  <= 1'b0;
                                r_halted <= 1'b1;
                            end else begin
                                r_phase <= C_FETCH;
                                r_first <= 1'b1;
                            end
                        end else begin
                            // Index p -> p+1 is a right shift (MSB = index 0).
                            r_phase <= r_phase >> 1;
                            r_first <= 1'b1;
                        end
                    end else begin
                        r_first <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_phase  <= '0;
                    r_first  <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign phase       = r_phase;
    assign phase_idx   = w_idx;
    assign phase_first = r_first;
    assign instr_done  = w_done;
    assign halted      = r_halted;

endmodule : phase_seq_gen
`default_nettype wire

// File: tb/tb_phase_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phase_seq_gen
//  Purpose  : Self-checking bench for phase_seq_gen. Runs a 4-phase and a
//             6-phase instance side by side against a behavioural model that
//             tracks (mode, phase index, cycles spent in phase).
//  Revision : 1.0  initial release
// ============================================================================
module tb_phase_seq_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, en, skip, halt_req, go;
    logic [15:0] cfg4;
    logic [23:0] cfg6;

    logic [3:0] ph4;
    logic [1:0] idx4;
    logic       f4, d4, h4;
    logic [5:0] ph6;
    logic [2:0] idx6;
    logic       f6, d6, h6;

    phase_seq_gen #(.NPHASE(4), .CNT_W(4), .IDX_W(2)) u4 (
        .clk(clk), .clr(clr), .en(en), .skip(skip), .halt_req(halt_req), .go(go),
        .dwell_cfg(cfg4), .phase(ph4), .phase_idx(idx4), .phase_first(f4),
        .instr_done(d4), .halted(h4)
    );

    phase_seq_gen #(.NPHASE(6), .CNT_W(4), .IDX_W(3)) u6 (
        .clk(clk), .clr(clr), .en(en), .skip(skip), .halt_req(halt_req), .go(go),
        .dwell_cfg(cfg6), .phase(ph6), .phase_idx(idx6), .phase_first(f6),
        .instr_done(d6), .halted(h6)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: mode 0 = idle, 1 = running, 2 = halted.
    int m_st[2];
    int m_idx[2];
    int m_cnt[2];
    bit m_first[2];
    bit skip6 = 1'b0;
    int done4_cnt = 0;
    int first4_cnt = 0;

    function automatic int nph(input int d);
        return (d == 0) ? 4 : 6;
    endfunction

    function automatic int cfg_of(input int d, input int k);
        if (d == 0) return int'(cfg4[k*4 +: 4]);
        return int'(cfg6[k*4 +: 4]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            int n;
            logic [31:0] e_ph, e_idx, e_done;
            logic [31:0] o_ph, o_idx, o_f, o_d, o_h;
            if (d == 1 && skip6) continue;
            n      = nph(d);
            e_ph   = (m_st[d] == 1) ? (32'd1 << (n - 1 - m_idx[d])) : 32'd0;
            e_idx  = (m_st[d] == 1) ? 32'(m_idx[d]) : 32'd0;
            e_done = 32'(!clr && en && m_st[d] == 1 && !skip && m_idx[d] == n - 1
                          && m_cnt[d] == cfg_of(d, m_idx[d]));
            o_ph  = (d == 0) ? 32'(ph4)  : 32'(ph6);
            o_idx = (d == 0) ? 32'(idx4) : 32'(idx6);
            o_f   = (d == 0) ? 32'(f4)   : 32'(f6);
            o_d   = (d == 0) ? 32'(d4)   : 32'(d6);
            o_h   = (d == 0) ? 32'(h4)   : 32'(h6);
            check($sformatf("phase_n%0d", n),       o_ph,  e_ph);
            check($sformatf("phase_idx_n%0d", n),   o_idx, e_idx);
            check($sformatf("phase_first_n%0d", n), o_f,   32'(m_first[d]));
            check($sformatf("instr_done_n%0d", n),  o_d,   e_done);
            check($sformatf("halted_n%0d", n),      o_h,   32'(m_st[d] == 2));
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int n, c;
            n = nph(d);
            c = cfg_of(d, m_idx[d]);
            if (clr) begin
                m_st[d] = 0; m_idx[d] = 0; m_cnt[d] = 0; m_first[d] = 0;
            end else if (!en) begin
                m_first[d] = 0;
            end else if (m_st[d] != 1) begin
                if (go) begin
                    m_st[d] = 1; m_idx[d] = 0; m_cnt[d] = 0; m_first[d] = 1;
                end else begin
                    m_first[d] = 0;
                end
            end else if (skip) begin
                m_idx[d] = 0; m_cnt[d] = 0; m_first[d] = 1;
            end else if (m_cnt[d] == c) begin
                m_cnt[d] = 0;
                if (m_idx[d] == n - 1) begin
                    m_idx[d] = 0;
                    if (halt_req) begin
                        m_st[d] = 2; m_first[d] = 0;
                    end else begin
                        m_first[d] = 1;
                    end
                end else begin
                    m_idx[d] = m_idx[d] + 1; m_first[d] = 1;
                end
            end else begin
                m_cnt[d] = (m_cnt[d] + 1) % 16; m_first[d] = 0;
            end
        end
    endtask

    // One clock: inputs already applied at the falling edge.
    task automatic cycle();
        #1;
        check_outputs();
        done4_cnt  += int'(d4);
        first4_cnt += int'(f4);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run_until(input int idx, input bit last);
        int k;
        for (k = 0; k < 60; k++) begin
            if (m_st[0] == 1 && m_idx[0] == idx && (!last || m_cnt[0] == cfg_of(0, idx))) break;
            cycle();
        end
        check("wait_bound", 32'(k < 60), 32'd1);
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; skip = 1'b0; halt_req = 1'b0; go = 1'b0;
        cfg4 = '0; cfg6 = '0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_idx[i] = 0; m_cnt[i] = 0; m_first[i] = 0;
        end
        repeat (2) begin
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
        clr = 1'b0;
        check("reset_phase", 32'(ph4), 32'd0);

        // Default rotation, one cycle per phase.
        en = 1'b1; go = 1'b1;
        cycle();
        go = 1'b0;
        done4_cnt = 0;
        repeat (8) cycle();
        check("rot_done_count", 32'(done4_cnt), 32'd2);

        // Dwell table: index0=0, index1=1, index2=2, index3=0 -> 7 cycles.
        cfg4 = {4'd0, 4'd2, 4'd1, 4'd0};
        cfg6 = {4'd1, 4'd0, 4'd2, 4'd0, 4'd1, 4'd0};
        run_until(3, 1'b1);
        cycle();
        done4_cnt = 0; first4_cnt = 0;
        repeat (7) cycle();
        check("dwell_first_count", 32'(first4_cnt), 32'd4);
        check("dwell_done_count", 32'(done4_cnt), 32'd1);

        // Stall in phase index 2 with cfg=1 at counter=1.
        cfg4 = {4'd0, 4'd1, 4'd1, 4'd0};
        run_until(2, 1'b1);
        en = 1'b0;
        repeat (3) cycle();
        check("stall_hold", 32'(ph4), 32'b0010);
        en = 1'b1;
        cycle();
        check("stall_resume", 32'(ph4), 32'b0001);

        // Skip from phase index 1, then skip together with halt at boundary.
        run_until(1, 1'b0);
        skip = 1'b1;
        cycle();
        skip = 1'b0;
        check("skip_to_fetch", 32'(ph4), 32'b1000);
        run_until(3, 1'b1);
        skip = 1'b1; halt_req = 1'b1;
        cycle();
        skip = 1'b0; halt_req = 1'b0;
        check("skip_beats_halt", 32'(h4), 32'd0);

        // Halt at boundary, hold, resume.
        run_until(3, 1'b1);
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        repeat (5) cycle();
        check("halt_held", 32'(h4), 32'd1);
        go = 1'b1;
        cycle();
        go = 1'b0;
        check("resume_phase", 32'(ph4), 32'b1000);

        // Mid-operation reset.
        run_until(3, 1'b0);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("midreset_phase", 32'(ph4), 32'd0);

        // Corrupted phase register on the 6-phase instance.
        go = 1'b1;
        cycle();
        go = 1'b0;
        repeat (3) cycle();
        force u6.r_phase = 6'b101000;
        skip6 = 1'b1;
        cycle();
        release u6.r_phase;
        m_st[1] = 0; m_idx[1] = 0; m_cnt[1] = 0; m_first[1] = 0;
        cycle();
        skip6 = 1'b0;
        check("seu_to_idle", 32'(ph6), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            clr      = ($urandom % 50) == 0;
            en       = ($urandom % 10) != 0;
            skip     = ($urandom % 12) == 0;
            halt_req = ($urandom % 3) == 0;
            go       = ($urandom % 4) == 0;
            if (($urandom % 8) == 0) begin
                cfg4 = 16'($urandom) & 16'h3333;
                cfg6 = 24'($urandom) & 24'h333333;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_phase_seq_gen
`default_nettype wire
